// File: rtl/halut_pkg.sv
`default_nettype none
// ============================================================================
// Module      : halut_pkg
// Description : Shared sizing constants for the HALUT LUT accumulator and
//               the logic that loads its lookup table.
//               K             - prototypes per codebook
//               C             - codebooks per row
//               DataTypeWidth - LUT entry width (two's complement)
//               AccWidth      - accumulator / result width
//               lut_addr_t    - LUT address, packed as {c, k}
// Revision    : 1.0 - initial release
// ============================================================================
package halut_pkg;

    localparam int K             = 16;
    localparam int C             = 32;
    localparam int DataTypeWidth = 16;
    // Wide enough to sum C full-scale entries without wrapping.
    localparam int AccWidth      = DataTypeWidth + $clog2(C);
    localparam int LutAddrWidth  = $clog2(C * K);

    typedef logic [LutAddrWidth-1:0] lut_addr_t;

endpackage
`default_nettype wire

// File: rtl/halut_lut_mem.sv
`default_nettype none
// ============================================================================
// Module      : halut_lut_mem
// Description : DEPTH x DATA_W lookup-table memory. One synchronous read
//               port and one write port. Contents are not reset.
// Ports       : clk_i    - clock, rising edge
//               re_i     - read enable; rdata_o updates on the next edge
//               raddr_i  - read address
//               rdata_o  - registered read data
//               we_i     - write enable
//               waddr_i  - write address
//               wdata_i  - write data
// Revision    : 1.0 - initial release
// ============================================================================
module halut_lut_mem #(
    parameter int DEPTH  = 512,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Read-before-write: a write is only visible to reads from the next edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            r_rdata <= r_mem[raddr_i];
        end
    end

    assign rdata_o = r_rdata;

endmodule
`default_nettype wire

// File: rtl/halut_lut_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : halut_lut_accumulator
// Description : Looks up one signed LUT entry per (c_addr, k_addr) pair from
//               the encoders and accumulates C of them into one row result.
//               Codebook arrival order is irrelevant; inputs are counted.
//               Stage 0 presents the address to the LUT, stage 1 adds the
//               returned entry. A completed row is reported with a one-cycle
//               valid_o pulse and the next row starts from zero with no bubble.
// Ports       : clk_i      - clock, rising edge
//               rst_i      - synchronous active-high reset
//               c_addr_i   - codebook index
//               k_addr_i   - prototype index
//               valid_i    - address pair valid (always accepted)
//               decoder_i  - run enable; low clears all row state
//               waddr_i    - LUT write address {c, k}
//               wdata_i    - LUT write data
//               we_i       - LUT write enable (honoured only with decoder_i low)
//               result_o   - signed row result
//               valid_o    - one-cycle pulse, result_o is new
//               overflow_o - saturation occurred in the reported row
// Config      : HALUT_ACC_SATURATE_EN - when defined, each addition saturates
//               and overflow_o reports it; otherwise addition wraps and
//               overflow_o is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module halut_lut_accumulator
    import halut_pkg::*;
#(
    parameter int K             = halut_pkg::K,
    parameter int C             = halut_pkg::C,
    parameter int DataTypeWidth = halut_pkg::DataTypeWidth,
    parameter int AccWidth      = DataTypeWidth + $clog2(C),
    parameter int TreeDepth     = $clog2(K),
    parameter int CAddrWidth    = $clog2(C),
    parameter int LutAddrWidth  = $clog2(C * K)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [CAddrWidth-1:0]    c_addr_i,
    input  logic [TreeDepth-1:0]     k_addr_i,
    input  logic                     valid_i,
    input  logic                     decoder_i,
    input  logic [LutAddrWidth-1:0]  waddr_i,
    input  logic [DataTypeWidth-1:0] wdata_i,
    input  logic                     we_i,
    output logic [AccWidth-1:0]      result_o,
    output logic                     valid_o,
    output logic                     overflow_o
);

    localparam logic [CAddrWidth-1:0] c_last_cnt = CAddrWidth'(C - 1);

    logic                     r_pending;
    logic [CAddrWidth-1:0]    r_row_cnt;
    logic [AccWidth-1:0]      r_acc;
    logic [AccWidth-1:0]      r_result;
    logic                     r_valid;

    logic [LutAddrWidth-1:0]  w_raddr;
    logic                     w_re;
    logic                     w_we;
    logic [DataTypeWidth-1:0] w_entry;
    logic [AccWidth-1:0]      w_entry_ext;
    logic [AccWidth-1:0]      w_acc_next;
    logic                     w_accum;
    logic                     w_last;

    assign w_raddr = LutAddrWidth'({c_addr_i, k_addr_i});
    assign w_re    = valid_i & decoder_i;
    // The table may only change while the datapath is idle.
    assign w_we    = we_i & ~decoder_i;

    halut_lut_mem #(
        .DEPTH  (C * K),
        .DATA_W (DataTypeWidth),
        .ADDR_W (LutAddrWidth)
    ) u_lut_mem (
        .clk_i   (clk_i),
        .re_i    (w_re),
        .raddr_i (w_raddr),
        .rdata_o (w_entry),
        .we_i    (w_we),
        .waddr_i (waddr_i),
        .wdata_i (wdata_i)
    );

    assign w_entry_ext = AccWidth'($signed(w_entry));
    // A pending entry only counts if the run is still enabled when it lands.
    assign w_accum     = r_pending & decoder_i;
    assign w_last      = w_accum & (r_row_cnt == c_last_cnt);

`ifdef HALUT_ACC_SATURATE_EN
    logic [AccWidth:0] w_sum_wide;
    logic              w_sat;
    logic              r_sticky;
    logic              r_overflow;

    assign w_sum_wide = {r_acc[AccWidth-1], r_acc} + {w_entry_ext[AccWidth-1], w_entry_ext};

    // Overflow shows as disagreement between the guard bit and the sign bit;
    // the guard bit then carries the true sign of the sum.
    always_comb begin
        w_sat      = w_sum_wide[AccWidth] ^ w_sum_wide[AccWidth-1];
        w_acc_next = w_sum_wide[AccWidth-1:0];
        if (w_sat) begin
            if (w_sum_wide[AccWidth]) begin
                w_acc_next = {1'b1, {(AccWidth-1){1'b0}}};
            end else begin
                w_acc_next = {1'b0, {(AccWidth-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sticky   <= 1'b0;
            r_overflow <= 1'b0;
        end else if (!decoder_i) begin
            r_sticky   <= 1'b0;
        end else if (w_accum) begin
            if (w_last) begin
                r_overflow <= r_sticky | w_sat;
                r_sticky   <= 1'b0;
            end else begin
                r_sticky   <= r_sticky | w_sat;
            end
        end
    end

    assign overflow_o = r_overflow;
`else
    assign w_acc_next = r_acc + w_entry_ext;
    assign overflow_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pending <= 1'b0;
            r_row_cnt <= '0;
            r_acc     <= '0;
            r_result  <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!decoder_i) begin
                // Clear wins over a completing entry; result_o holds.
                r_pending <= 1'b0;
                r_row_cnt <= '0;
                r_acc     <= '0;
            end else begin
                r_pending <= valid_i;
                if (r_pending) begin
                    if (w_last) begin
                        r_result  <= w_acc_next;
                        r_valid   <= 1'b1;
                        r_acc     <= '0;
                        r_row_cnt <= '0;
                    end else begin
                        r_acc     <= w_acc_next;
                        r_row_cnt <= r_row_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign result_o = r_result;
    assign valid_o  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_halut_lut_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_halut_lut_accumulator
// Description : Scoreboard bench for halut_lut_accumulator. A reference model
//               follows the row rules on every clock and queues the expected
//               row results; a monitor compares each valid_o pulse.
//               The DUT is built with a 16-bit accumulator so that the
//               saturation / wrap behaviour is reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_halut_lut_accumulator;

    localparam int TB_K  = 16;
    localparam int TB_C  = 32;
    localparam int TB_DW = 16;
    localparam int TB_AW = 16;
    localparam int TB_CW = 5;
    localparam int TB_KW = 4;
    localparam int TB_LW = 9;
    localparam longint MAXV = (longint'(1) << (TB_AW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (TB_AW - 1));

    logic                clk       = 1'b0;
    logic                rst_i     = 1'b1;
    logic [TB_CW-1:0]    c_addr_i  = '0;
    logic [TB_KW-1:0]    k_addr_i  = '0;
    logic                valid_i   = 1'b0;
    logic                decoder_i = 1'b0;
    halut_pkg::lut_addr_t waddr_i  = '0;
    logic [TB_DW-1:0]    wdata_i   = '0;
    logic                we_i      = 1'b0;
    logic [TB_AW-1:0]    result_o;
    logic                valid_o;
    logic                overflow_o;

    halut_lut_accumulator #(
        .K             (TB_K),
        .C             (TB_C),
        .DataTypeWidth (TB_DW),
        .AccWidth      (TB_AW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .c_addr_i   (c_addr_i),
        .k_addr_i   (k_addr_i),
        .valid_i    (valid_i),
        .decoder_i  (decoder_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .we_i       (we_i),
        .result_o   (result_o),
        .valid_o    (valid_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [TB_AW-1:0] res;
        bit               ovf;
        int               at;
    } exp_t;

    exp_t   sbq[$];
    exp_t   m_e;
    exp_t   mon_e;
    int     lut_m [TB_C*TB_K];
    longint m_sum      = 0;
    int     m_cnt      = 0;
    bit     m_sat      = 1'b0;
    bit     m_pend     = 1'b0;
    int     m_pend_val = 0;
    int     cyc        = 0;
    int     n_pulses   = 0;

    function automatic void model_add(input int v);
        m_sum = m_sum + longint'(v);
`ifdef HALUT_ACC_SATURATE_EN
        if (m_sum > MAXV) begin
            m_sum = MAXV;
            m_sat = 1'b1;
        end else if (m_sum < MINV) begin
            m_sum = MINV;
            m_sat = 1'b1;
        end
`endif
    endfunction

    // An input read at one edge is added at the next edge, provided the run
    // is still enabled there; the C-th added entry completes the row.
    always @(posedge clk) begin
        cyc++;
        if (we_i && !decoder_i) begin
            lut_m[waddr_i] = int'($signed(wdata_i));
        end
        if (rst_i || !decoder_i) begin
            m_sum  = 0;
            m_cnt  = 0;
            m_sat  = 1'b0;
            m_pend = 1'b0;
        end else begin
            if (m_pend) begin
                model_add(m_pend_val);
                m_cnt++;
                if (m_cnt == TB_C) begin
                    m_e.res = m_sum[TB_AW-1:0];
                    m_e.ovf = m_sat;
                    m_e.at  = cyc;
                    sbq.push_back(m_e);
                    m_sum = 0;
                    m_cnt = 0;
                    m_sat = 1'b0;
                end
            end
            m_pend     = valid_i;
            m_pend_val = lut_m[{c_addr_i, k_addr_i}];
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (valid_o) begin
            n_pulses++;
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got result 0x%0h, required no pulse", result_o);
            end else begin
                mon_e = sbq.pop_front();
                check("row_result",   longint'(result_o),   longint'(mon_e.res));
                check("row_overflow", longint'(overflow_o), longint'(mon_e.ovf));
                check("row_latency",  longint'(cyc),        longint'(mon_e.at));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input int c, input int k);
        @(negedge clk);
        valid_i  = v;
        c_addr_i = c[TB_CW-1:0];
        k_addr_i = k[TB_KW-1:0];
        we_i     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0);
    endtask

    task automatic set_dec(input bit d);
        @(negedge clk);
        decoder_i = d;
        valid_i   = 1'b0;
        we_i      = 1'b0;
    endtask

    task automatic lut_write(input int a, input logic [TB_DW-1:0] d);
        @(negedge clk);
        decoder_i = 1'b0;
        valid_i   = 1'b0;
        we_i      = 1'b1;
        waddr_i   = a[TB_LW-1:0];
        wdata_i   = d;
    endtask

    // One full row; gaps only between inputs so consecutive rows abut.
    task automatic feed_row(input bit shuf, input int gap_max, input bit rand_k);
        int order[TB_C];
        for (int i = 0; i < TB_C; i++) order[i] = i;
        if (shuf) begin
            for (int i = TB_C - 1; i > 0; i--) begin
                int j;
                int t;
                j        = int'($urandom_range(i, 0));
                t        = order[i];
                order[i] = order[j];
                order[j] = t;
            end
        end
        for (int i = 0; i < TB_C; i++) begin
            if (i > 0 && gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
            drive(1'b1, order[i], rand_k ? int'($urandom_range(TB_K - 1, 0)) : 0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_result",   longint'(result_o),   0);
        check("reset_valid",    longint'(valid_o),    0);
        check("reset_overflow", longint'(overflow_o), 0);
        rst_i = 1'b0;

        // LUT[c][k] = c+1, so any full row sums to 528.
        for (int a = 0; a < TB_C * TB_K; a++) lut_write(a, TB_DW'(a / TB_K + 1));
        set_dec(1'b1);

        // Basic row, k = 0, c in order.
        feed_row(1'b0, 0, 1'b0);
        idle(4);

        // Two shuffled rows with gaps, back to back.
        feed_row(1'b1, 2, 1'b1);
        feed_row(1'b1, 2, 1'b1);
        idle(4);

        // Abort after 10 inputs, then a full row.
        for (int i = 0; i < 10; i++) drive(1'b1, i, int'($urandom_range(TB_K - 1, 0)));
        set_dec(1'b0);
        set_dec(1'b1);
        feed_row(1'b1, 1, 1'b1);
        idle(4);

        // Run enable drops right after the completing input: no pulse.
        feed_row(1'b1, 0, 1'b1);
        set_dec(1'b0);
        idle(3);
        set_dec(1'b1);

        // Write while running must be ignored.
        @(negedge clk);
        we_i    = 1'b1;
        waddr_i = TB_LW'($urandom_range(TB_C * TB_K - 1, 0));
        wdata_i = 16'h1234;
        valid_i = 1'b0;
        drive(1'b0, 0, 0);
        feed_row(1'b1, 1, 1'b1);
        idle(4);

        // Random signed table contents, several random rows.
        set_dec(1'b0);
        for (int a = 0; a < TB_C * TB_K; a++) lut_write(a, TB_DW'($urandom));
        set_dec(1'b1);
        repeat (6) feed_row(1'b1, 3, 1'b1);
        idle(4);

        // Every entry at full scale: saturates or wraps depending on build.
        set_dec(1'b0);
        for (int a = 0; a < TB_C * TB_K; a++) lut_write(a, 16'h7FFF);
        set_dec(1'b1);
        feed_row(1'b0, 0, 1'b1);
        idle(6);

        check("drain_empty", longint'(sbq.size()), 0);
        check("pulse_count", longint'(n_pulses), 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/halut_lut_accumulator.md
# halut_lut_accumulator

- Sits directly downstream of the encoder units.
- Per valid `(c_addr, k_addr)` pair, reads one signed entry from a local lookup-table memory.
- Accumulates C such entries (one per codebook) into a single dot-product result for one output column.
- Emits the result with a one-cycle valid pulse and restarts for the next row.

## Interface
Parameters:
- `K`, `halut_pkg::K` (16): prototypes per codebook.
- `C`, `halut_pkg::C` (32): codebooks per row.
- `DataTypeWidth`, `halut_pkg::DataTypeWidth` (16): LUT entry width, two's complement.
- `AccWidth`, `DataTypeWidth + $clog2(C)`: accumulator/result width.
- `TreeDepth`, `$clog2(K)`: k address width.
- `CAddrWidth`, `$clog2(C)`: c address width.
- `LutAddrWidth`, `$clog2(C*K)`: LUT address width.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `c_addr_i`  in  CAddrWidth  codebook index from encoder.
- `k_addr_i`  in  TreeDepth  prototype index from encoder.
- `valid_i`  in  1  address pair valid; no backpressure, always accepted.
- `decoder_i`  in  1  run enable; low clears all row state.
- `waddr_i`  in  LutAddrWidth  LUT write address, `{c, k}`.
- `wdata_i`  in  DataTypeWidth  LUT write data.
- `we_i`  in  1  LUT write enable.
- `result_o`  out  AccWidth  signed row result.
- `valid_o`  out  1  one-cycle pulse, result_o is new.
- `overflow_o`  out  1  saturation occurred in the reported row.

## Operation
- LUT read address is `{c_addr_i, k_addr_i}`.
- Arrival order of codebooks is irrelevant: inputs from interleaved encoder units are simply counted.
- Pipeline stage 0 (read): when `valid_i && decoder_i`, the address is presented to the LUT and a pending flag is set.
- Pipeline stage 1 (accumulate):
  - The pending entry is sign-extended to AccWidth and added to `acc`.
  - `row_cnt` (`$clog2(C)` bits) increments.
- Row completion: when the pending entry is the C-th one (`row_cnt == C-1`):
  - `result_o <= acc + entry` and `valid_o <= 1`.
  - `acc <= 0` and `row_cnt <= 0` (wrap).
  - `overflow_o <=` the row's sticky overflow flag; the sticky flag then clears.
- `valid_o` is deasserted on every other cycle. `result_o` and `overflow_o` hold until the next completion.
- `decoder_i` low, on the next edge:
  - `acc`, `row_cnt`, the pending flag, the sticky flag and `valid_o` clear.
  - `result_o` and `overflow_o` hold.
  - In-flight inputs are discarded.
- LUT writes:
  - Accepted only when `decoder_i` is low.
  - `we_i` while `decoder_i` is high is ignored; the LUT is unchanged.
- LUT contents are not reset.
- Reset values: `result_o = 0`, `valid_o = 0`, `overflow_o = 0`; `acc`, `row_cnt`, the pending flag and the sticky flag are all 0.
- Reset mid-row discards the partial sum and all in-flight data.

## Timing
- Throughput: one input per cycle, sustained indefinitely.
- LUT read is synchronous: data is valid in the cycle after the address edge.
- Latency: input sampled at edge t → accumulated at edge t+1. A C-th input sampled at edge t gives `valid_o` high during cycle t+1..t+2.
- Row boundary: an input of the next row in the cycle immediately after the C-th input accumulates from 0 with no bubble.
- `decoder_i` falling in the same cycle as a completing input: the clear wins, `valid_o` is not asserted, and `result_o` holds.
- A write at edge t is visible to reads from edge t+1.

## Configuration
- `HALUT_ACC_SATURATE_EN` defined:
  - Each addition saturates to `2^(AccWidth-1)-1` / `-2^(AccWidth-1)`.
  - Any saturation in a row sets the sticky flag, reported on `overflow_o` with that row's result.
- `HALUT_ACC_SATURATE_EN` undefined:
  - Addition wraps modulo `2^AccWidth`.
  - `overflow_o` is tied to 0.

## Structure
- `halut_pkg` holds `K`, `C` and `DataTypeWidth`, plus a new `AccWidth` constant and a `lut_addr_t` typedef shared with the write-loading logic.
- The LUT memory is one sub-module, `halut_lut_mem`:
  - C·K × DataTypeWidth.
  - One synchronous read port, one write port, no reset.
- All control and datapath logic lives in `halut_lut_accumulator`.

## Test plan
- Reset: assert `rst_i` for 2 cycles → `result_o = 0`, `valid_o = 0`, `overflow_o = 0`.
- Basic row: load LUT[c][k] = c+1; feed k = 0 for c = 0..31 on consecutive cycles → exactly one `valid_o` pulse, 2 cycles after the last input, with `result_o = 528`.
- Back-to-back rows with shuffled c order and gaps in `valid_i` → two results, both 528, with no bubble at the row boundary.
- Abort: drop `decoder_i` after 10 inputs, then re-raise and feed a full row → no pulse for the aborted row; next result is 528.
- Write guard: assert `we_i` with `decoder_i` high → LUT unchanged, and the following row result is unchanged.
- Overflow: all entries = 0x7FFF with AccWidth = 16 → with the macro, `result_o = 0x7FFF` and `overflow_o = 1`; without it, the wrapped value with `overflow_o = 0`.
